// File: rtl/fp_credit_res_buffer.sv
// Credit-based result buffer behind the stall-free FP datapath.
// Admits arguments only when a FIFO slot is reserved for the result.
module fp_credit_res_buffer #(
  parameter int FLEN  = 64,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arg_vld,
  output logic            arg_rdy,
  output logic            issue,
  input  logic            pipe_vld,
  input  logic [FLEN-1:0] pipe_res,
  output logic            res_vld,
  input  logic            res_rdy,
  output logic [FLEN-1:0] res,
  output logic            ovf_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [FLEN-1:0]  mem [DEPTH];
  logic [CNT_W-1:0] credit_cnt;
  logic [CNT_W-1:0] occ;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             pop;
  logic             push;
  logic             full;
  logic             stray;

  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign arg_rdy = credit_cnt < FULL;
  assign issue   = arg_vld & arg_rdy;
  assign res_vld = occ != '0;
  assign res     = mem[rd_ptr];
  assign full    = occ == FULL;
  assign pop     = res_vld & res_rdy;
  assign push    = pipe_vld & (~full | pop);
  assign stray   = pipe_vld & (credit_cnt == occ);

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_cnt <= '0;
      occ        <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      ovf_err    <= 1'b0;
    end else begin
      // credit floor at zero keeps a stray result from wrapping the count
      if (issue & ~pop)
        credit_cnt <= credit_cnt + CNT_W'(1);
      else if (~issue & pop & (credit_cnt != '0))
        credit_cnt <= credit_cnt - CNT_W'(1);
      if (push & ~pop)
        occ <= occ + CNT_W'(1);
      else if (~push & pop)
        occ <= occ - CNT_W'(1);
      if (push)
        wr_ptr <= inc(wr_ptr);
      if (pop)
        rd_ptr <= inc(rd_ptr);
      if ((pipe_vld & full & ~pop) | stray)
        ovf_err <= 1'b1;
    end
  end

  // when full, push+pop share a slot: the head is read before it is rewritten
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= pipe_res;
  end

endmodule
